// File: rtl/mlp_pkg.sv
// mlp_pkg: shared sizes, byte type and loader state encoding for the MLP parameter loader.
package mlp_pkg;
  localparam int N_IN  = 6;
  localparam int N_HID = 16;
  localparam int N_OUT = 3;
  typedef logic [7:0] byte_t;
  typedef enum logic [2:0] {IDLE, L_W1, L_B1, L_W2, L_B2, L_X} ld_state_t;
  localparam int LEN_W1    = N_IN * N_HID;
  localparam int LEN_B1    = N_HID;
  localparam int LEN_W2    = N_HID * N_OUT;
  localparam int LEN_B2    = N_OUT;
  localparam int LEN_X     = N_IN;
  localparam int FRAME_LEN = LEN_W1 + LEN_B1 + LEN_W2 + LEN_B2 + LEN_X;
endpackage

// File: rtl/mlp_param_loader.sv
// mlp_param_loader: deserialises a byte stream into MLP weights, biases and input vector.
module mlp_param_loader
  import mlp_pkg::*;
#(
  parameter int N_IN  = mlp_pkg::N_IN,
  parameter int N_HID = mlp_pkg::N_HID,
  parameter int N_OUT = mlp_pkg::N_OUT
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  s_valid,
  output logic  s_ready,
  input  byte_t s_data,
  input  logic  s_sof,
  input  logic  s_xonly,
  output byte_t w1_o [N_IN][N_HID],
  output byte_t b1_o [N_HID],
  output byte_t w2_o [N_HID][N_OUT],
  output byte_t b2_o [N_OUT],
  output byte_t din_o [N_IN],
  output logic  params_ok,
  output logic  x_ok,
  output logic  done,
  output logic  err
);
  localparam int LW1  = N_IN * N_HID;
  localparam int LW2  = N_HID * N_OUT;
  localparam int MAXL = LW1 > LW2 ? LW1 : LW2;
  localparam int CW   = $clog2(MAXL + 1);
  ld_state_t state, state_d, wst;
  logic [CW-1:0] cnt, cnt_d, widx, last_idx;
  logic acc, last, wen, err_set, done_set, pok_set, pok_clr, xok_set, xok_clr;
  assign acc = s_valid && s_ready;
  assign last_idx = state == L_W1 ? CW'(LW1 - 1) :
                    state == L_B1 ? CW'(N_HID - 1) :
                    state == L_W2 ? CW'(LW2 - 1) :
                    state == L_B2 ? CW'(N_OUT - 1) :
                    state == L_X  ? CW'(N_IN - 1) : CW'(0);
  assign last = cnt == last_idx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    wst      = state;
    widx     = cnt;
    wen      = 1'b0;
    err_set  = 1'b0;
    done_set = 1'b0;
    pok_set  = 1'b0;
    pok_clr  = 1'b0;
    xok_set  = 1'b0;
    xok_clr  = 1'b0;
    if (acc) begin
      if (s_sof && s_xonly && !params_ok) begin
        err_set = 1'b1;
        state_d = IDLE;
        cnt_d   = '0;
      end else if (s_sof) begin
        // SOF byte is element 0 of the new frame; any frame in flight is abandoned
        err_set = state != IDLE;
        wen     = 1'b1;
        wst     = s_xonly ? L_X : L_W1;
        widx    = '0;
        state_d = wst;
        cnt_d   = CW'(1);
        xok_clr = 1'b1;
        pok_clr = !s_xonly;
      end else if (state == IDLE) begin
        err_set = 1'b1;
      end else begin
        wen      = 1'b1;
        state_d  = !last ? state : state == L_X ? IDLE : ld_state_t'(state + 3'd1);
        cnt_d    = last ? '0 : cnt + CW'(1);
        pok_set  = last && state == L_B2;
        xok_set  = last && state == L_X;
        done_set = last && state == L_X;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ready   <= 1'b0;
      params_ok <= 1'b0;
      x_ok      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      s_ready   <= 1'b1;
      done      <= done_set;
      err       <= err | err_set;
      params_ok <= pok_clr ? 1'b0 : pok_set ? 1'b1 : params_ok;
      x_ok      <= xok_clr ? 1'b0 : xok_set ? 1'b1 : x_ok;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_IN; i++)
        for (int j = 0; j < N_HID; j++) w1_o[i][j] <= '0;
      for (int i = 0; i < N_HID; i++)
        for (int j = 0; j < N_OUT; j++) w2_o[i][j] <= '0;
      for (int i = 0; i < N_HID; i++) b1_o[i] <= '0;
      for (int i = 0; i < N_OUT; i++) b2_o[i] <= '0;
      for (int i = 0; i < N_IN; i++) din_o[i] <= '0;
    end else if (wen) begin
      for (int i = 0; i < N_IN; i++)
        for (int j = 0; j < N_HID; j++)
          if (wst == L_W1 && widx == CW'(i * N_HID + j)) w1_o[i][j] <= s_data;
      for (int i = 0; i < N_HID; i++)
        for (int j = 0; j < N_OUT; j++)
          if (wst == L_W2 && widx == CW'(i * N_OUT + j)) w2_o[i][j] <= s_data;
      for (int i = 0; i < N_HID; i++)
        if (wst == L_B1 && widx == CW'(i)) b1_o[i] <= s_data;
      for (int i = 0; i < N_OUT; i++)
        if (wst == L_B2 && widx == CW'(i)) b2_o[i] <= s_data;
      for (int i = 0; i < N_IN; i++)
        if (wst == L_X && widx == CW'(i)) din_o[i] <= s_data;
    end
  end
endmodule

// File: tb/tb_mlp_param_loader.sv
// tb_mlp_param_loader: scoreboard per accepted byte plus table-driven spot checks of frame results.
module tb_mlp_param_loader;
  import mlp_pkg::*;
  typedef struct {int sec; int idx; int val;} rec_t;
  logic  clk = 1'b0, rst_n = 1'b0, s_valid = 1'b0, s_sof = 1'b0, s_xonly = 1'b0;
  byte_t s_data = '0;
  logic  s_ready, params_ok, x_ok, done, err;
  byte_t w1_o [N_IN][N_HID];
  byte_t b1_o [N_HID];
  byte_t w2_o [N_HID][N_OUT];
  byte_t b2_o [N_OUT];
  byte_t din_o [N_IN];
  int checks = 0, errors = 0, done_cnt = 0, d0;
  rec_t sb[$];
  rec_t tbl[6];
  mlp_param_loader dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_sof(s_sof), .s_xonly(s_xonly), .w1_o(w1_o), .b1_o(b1_o), .w2_o(w2_o), .b2_o(b2_o),
    .din_o(din_o), .params_ok(params_ok), .x_ok(x_ok), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (done === 1'b1) done_cnt++;
  function automatic int rd(input int sec, input int idx);
    case (sec)
      0: return int'(w1_o[idx / N_HID][idx % N_HID]);
      1: return int'(b1_o[idx]);
      2: return int'(w2_o[idx / N_OUT][idx % N_OUT]);
      3: return int'(b2_o[idx]);
      default: return int'(din_o[idx]);
    endcase
  endfunction
  function automatic int sec_len(input int sec);
    return sec == 0 ? LEN_W1 : sec == 1 ? LEN_B1 : sec == 2 ? LEN_W2 : sec == 3 ? LEN_B2 : LEN_X;
  endfunction
  function automatic int count_ne(input int v);
    int n = 0;
    for (int s = 0; s < 5; s++)
      for (int k = 0; k < sec_len(s); k++) if (rd(s, k) != v) n++;
    return n;
  endfunction
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic put(input byte_t d, input logic sof, input logic xo, input int sec, input int idx,
                     input bit chk, input int gap);
    rec_t e;
    for (int g = 0; g < 8 && int'($urandom_range(99)) < gap; g++) begin
      s_valid = 1'b0;
      @(posedge clk); #1;
    end
    s_valid = 1'b1; s_data = d; s_sof = sof; s_xonly = xo;
    if (chk) sb.push_back('{sec, idx, int'(d)});
    @(posedge clk); #1;
    s_valid = 1'b0; s_sof = 1'b0;
    if (chk) begin
      if (sb.size() == 0) check("scoreboard_empty", 1, 0);
      else begin
        e = sb.pop_front();
        check($sformatf("elem s%0d i%0d", e.sec, e.idx), rd(e.sec, e.idx), e.val);
      end
    end
  endtask
  task automatic frame(input bit xo, input int n, input int mode, input int gap);
    int sec, idx, q;
    byte_t v;
    for (int p = 0; p < n; p++) begin
      v = mode == 0 ? byte_t'(p) : mode == 1 ? 8'hFF : byte_t'(8'hA0 + p);
      if (xo) begin sec = 4; idx = p; end
      else begin
        sec = 0; q = p;
        while (q >= sec_len(sec)) begin q -= sec_len(sec); sec++; end
        idx = q;
      end
      put(v, p == 0, xo, sec, idx, 1'b1, gap);
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0; s_valid = 1'b0; s_sof = 1'b0; s_xonly = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask
  task automatic run_table(input string tag);
    for (int k = 0; k < 6; k++)
      check($sformatf("%s s%0d i%0d", tag, tbl[k].sec, tbl[k].idx), rd(tbl[k].sec, tbl[k].idx), tbl[k].val);
  endtask
  task automatic full_result(input string tag, input int gap);
    d0 = done_cnt;
    frame(1'b0, FRAME_LEN, 0, gap);
    check({tag, " params_ok"}, int'(params_ok), 1);
    check({tag, " x_ok"}, int'(x_ok), 1);
    check({tag, " done"}, int'(done), 1);
    @(posedge clk); #1;
    check({tag, " done_one_cycle"}, int'(done), 0);
    check({tag, " done_count"}, done_cnt - d0, 1);
    check({tag, " err"}, int'(err), 0);
    tbl[0] = '{0, 0, 0};   tbl[1] = '{0, 95, 95}; tbl[2] = '{1, 15, 111};
    tbl[3] = '{2, 47, 159}; tbl[4] = '{3, 2, 162}; tbl[5] = '{4, 5, 168};
    run_table(tag);
  endtask
  initial begin
    repeat (2) @(posedge clk); #1;
    check("rst s_ready", int'(s_ready), 0);
    check("rst params_ok", int'(params_ok), 0);
    check("rst x_ok", int'(x_ok), 0);
    check("rst done", int'(done), 0);
    check("rst err", int'(err), 0);
    check("rst arrays_nonzero", count_ne(0), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("s_ready after release", int'(s_ready), 1);
    // x-only SOF with no parameters loaded is rejected
    d0 = done_cnt;
    put(8'h55, 1'b1, 1'b1, 4, 0, 1'b0, 0);
    check("xonly_early err", int'(err), 1);
    check("xonly_early x_ok", int'(x_ok), 0);
    check("xonly_early din0", int'(din_o[0]), 0);
    @(posedge clk); #1;
    check("xonly_early no_done", done_cnt - d0, 0);
    do_reset();
    full_result("full", 0);
    d0 = done_cnt;
    put(8'hA0, 1'b1, 1'b1, 4, 0, 1'b1, 0);
    check("xonly x_ok_cleared", int'(x_ok), 0);
    check("xonly params_ok_kept", int'(params_ok), 1);
    for (int p = 1; p < N_IN; p++) put(byte_t'(8'hA0 + p), 1'b0, 1'b0, 4, p, 1'b1, 0);
    check("xonly x_ok_set", int'(x_ok), 1);
    check("xonly done", int'(done), 1);
    check("xonly params_ok", int'(params_ok), 1);
    check("xonly err", int'(err), 0);
    for (int k = 0; k < 6; k++) tbl[k] = '{4, k, 8'hA0 + k};
    run_table("xonly din");
    check("xonly w1_unchanged", int'(w1_o[5][15]), 95);
    check("xonly b2_unchanged", int'(b2_o[2]), 162);
    @(posedge clk); #1;
    check("xonly done_count", done_cnt - d0, 1);
    do_reset();
    full_result("gaps", 50);
    do_reset();
    d0 = done_cnt;
    frame(1'b0, 50, 0, 0);
    check("abort no_done_yet", done_cnt - d0, 0);
    frame(1'b0, FRAME_LEN, 1, 0);
    @(posedge clk); #1;
    check("abort err", int'(err), 1);
    check("abort arrays_not_ff", count_ne(255), 0);
    check("abort params_ok", int'(params_ok), 1);
    check("abort x_ok", int'(x_ok), 1);
    check("abort done_count", done_cnt - d0, 1);
    do_reset();
    frame(1'b0, 100, 0, 0);
    rst_n = 1'b0;
    #1;
    check("midrst arrays_nonzero", count_ne(0), 0);
    check("midrst params_ok", int'(params_ok), 0);
    check("midrst s_ready", int'(s_ready), 0);
    check("midrst err", int'(err), 0);
    sb.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    d0 = done_cnt;
    put(8'h33, 1'b0, 1'b0, 0, 0, 1'b0, 0);
    check("midrst nonsof err", int'(err), 1);
    check("midrst nonsof discarded", int'(w1_o[0][0]), 0);
    put(8'h44, 1'b0, 1'b0, 0, 0, 1'b0, 0);
    check("midrst still_discarding", int'(w1_o[0][1]), 0);
    check("midrst no_done", done_cnt - d0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mlp_param_loader.md
MLP_PARAM_LOADER -- requirements
Module: mlp_param_loader

Interface
REQ-001 N_IN, 6, input vector length; default from mlp_pkg.
REQ-002 N_HID, 16, hidden layer width; default from mlp_pkg.
REQ-003 N_OUT, 3, output layer width; default from mlp_pkg.
REQ-004 The clock SHALL be clk, single clock domain, rising edge; the reset SHALL be rst_n, asynchronous, active-low.
REQ-005 clk  in  1  sole clock.
REQ-006 rst_n  in  1  async active-low reset.
REQ-007 s_valid  in  1  byte-stream valid.
REQ-008 s_ready  out  1  byte-stream ready.
REQ-009 s_data  in  8  stream byte.
REQ-010 s_sof  in  1  first byte of frame; qualified by s_valid.
REQ-011 s_xonly  in  1  frame type at SOF: 1 = input-vector-only frame, 0 = full frame.
REQ-012 w1_o  out  8x[N_IN][N_HID]  layer-1 weights to MLP.
REQ-013 b1_o  out  8x[N_HID]  layer-1 biases.
REQ-014 w2_o  out  8x[N_HID][N_OUT]  layer-2 weights.
REQ-015 b2_o  out  8x[N_OUT]  layer-2 biases.
REQ-016 din_o  out  8x[N_IN]  input vector.
REQ-017 params_ok  out  1  all weights/biases loaded and consistent.
REQ-018 x_ok  out  1  din_o holds a complete vector.
REQ-019 done  out  1  one-cycle pulse at frame completion.
REQ-020 err  out  1  sticky protocol error; cleared only by reset.

Function
REQ-021 A byte SHALL transfer on a rising clk edge with s_valid && s_ready; s_ready SHALL be 1 in every state after reset release (no backpressure), 0 during reset.
REQ-022 FSM states SHALL be IDLE, L_W1, L_B1, L_W2, L_B2, L_X.
REQ-023 Full frame order: w1 row-major (i=0..N_IN-1 outer, j=0..N_HID-1 inner), b1[0..], w2 row-major (i over N_HID, j over N_OUT), b2[0..], din[0..]; 96+16+48+3+6 = 169 bytes at defaults.
REQ-024 x-only frame SHALL contain exactly N_IN bytes written to din_o[0..N_IN-1].
REQ-025 An SOF byte accepted in any state SHALL start a new frame and be stored as element 0 of that frame (L_W1 for full, L_X for x-only), aborting any frame in progress.
REQ-026 A single element counter SHALL index within the current section; at last element it SHALL zero and advance state; after the last din byte state SHALL return to IDLE.
REQ-027 Each accepted byte SHALL appear on its output element the cycle after acceptance; untouched elements SHALL hold.
REQ-028 Full-frame SOF SHALL clear params_ok and x_ok in the next cycle; params_ok SHALL set the cycle after the last b2 byte; x_ok SHALL set the cycle after the last din byte.
REQ-029 x-only SOF SHALL clear x_ok only; params_ok unaffected.
REQ-030 done SHALL pulse for exactly one cycle, the cycle after the final byte of any frame; aborted frames SHALL NOT pulse done.
REQ-031 Non-SOF byte accepted in IDLE SHALL be discarded and set err.
REQ-032 x-only SOF while params_ok = 0 SHALL set err, be discarded, and leave state IDLE.
REQ-033 SOF abort mid-frame SHALL set err; partially written elements SHALL keep the new data.
REQ-034 s_valid = 0 cycles SHALL stall the FSM and counter with no effect on outputs.

Reset
REQ-035 On rst_n low: state IDLE, counter 0, all array outputs 0, params_ok/x_ok/done/err 0, s_ready 0.
REQ-036 Reset asserted mid-frame SHALL discard the frame entirely; first post-reset byte must carry SOF.

Structure
REQ-037 mlp_pkg SHALL hold N_IN, N_HID, N_OUT, byte_t (logic [7:0]), loader state enum, per-section lengths.
REQ-038 Implementation SHALL be a single module with no sub-modules; storage in output-driving registers.

Verification
REQ-039 Full frame bytes 0..168 (value = index mod 256), continuous valid -> w1_o[0][0]=0, w1_o[5][15]=95, b1_o[15]=111, w2_o[15][2]=159, b2_o[2]=162, din_o[5]=168; params_ok, x_ok, done high 1 cycle after byte 168.
REQ-040 After REQ-039, x-only frame 0xA0..0xA5 -> din_o=A0..A5, params_ok stays 1, x_ok drops after SOF and returns after last byte, weights unchanged.
REQ-041 x-only SOF straight after reset -> err=1, state IDLE, x_ok=0, no done.
REQ-042 Full frame aborted by SOF at byte 50, then full frame of 169 bytes 0xFF -> err=1, all arrays 0xFF, params_ok=1, single done.
REQ-043 Random s_valid gaps (50%) over full frame -> identical result to REQ-039.
REQ-044 rst_n low at byte 100 then released -> all outputs 0; non-SOF byte next -> err=1.
